// File: rtl/map_write_arbiter.sv
// Tile-map write port arbiter: round-robin over bomb/treasure requesters,
// range rejection, and a full-map fill sweep.
`timescale 1ns/1ps
module map_write_arbiter #(
    parameter int NREQ = 10,
    parameter int COLS = 16,
    parameter int ROWS = 12,
    parameter int AW   = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              sweep_start,
    input  logic [3:0]        sweep_tile,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*4-1:0] req_x,
    input  logic [NREQ*4-1:0] req_y,
    input  logic [NREQ*4-1:0] req_tile,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   drop,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [3:0]        wr_data,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;
    localparam logic [AW-1:0] LAST    = AW'(COLS * ROWS - 1);
    localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);

    logic [0:0]      state;
    logic [AW-1:0]   cnt;
    logic [3:0]      tile_q;
    logic [PW-1:0]   ptr;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] in_rng;
    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] drop_nxt;
    logic            win_found;
    logic [PW-1:0]   win;
    logic [AW-1:0]   win_addr;
    logic [3:0]      win_tile;
    logic [3:0]      rx;
    logic [3:0]      ry;

    // A requester still holding req in its gnt/drop cycle is masked out.
    assign elig = req & ~gnt & ~drop;

    always_comb begin
        in_rng = '0;
        for (int i = 0; i < NREQ; i++) begin
            in_rng[i] = (32'(req_y[i*4 +: 4]) < ROWS) &&
                        (32'(req_x[i*4 +: 4]) < COLS);
        end
    end

    assign cand     = elig & in_rng;
    assign drop_nxt = elig & ~in_rng;

    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win       = PW'(idx);
            end
        end
    end

    always_comb begin
        rx       = req_x[int'(win)*4 +: 4];
        ry       = req_y[int'(win)*4 +: 4];
        win_tile = req_tile[int'(win)*4 +: 4];
        win_addr = AW'(32'(ry) * COLS + 32'(rx));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            tile_q  <= '0;
            ptr     <= PTR_RST;
            gnt     <= '0;
            drop    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
        end else begin
            gnt   <= '0;
            drop  <= '0;
            wr_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (sweep_start) begin
                        // The accepting edge already issues address 0.
                        state   <= SWEEP;
                        tile_q  <= sweep_tile;
                        busy    <= 1'b1;
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= sweep_tile;
                        cnt     <= AW'(1);
                    end else begin
                        drop <= drop_nxt;
                        if (win_found) begin
                            gnt     <= NREQ'(1) << win;
                            wr_en   <= 1'b1;
                            wr_addr <= win_addr;
                            wr_data <= win_tile;
                            ptr     <= win;
                        end
                    end
                end
                SWEEP: begin
                    busy    <= 1'b1;
                    wr_en   <= 1'b1;
                    wr_addr <= cnt;
                    wr_data <= tile_q;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_map_write_arbiter.sv
// Directed bench for map_write_arbiter: reset, grants, round-robin,
// range drops, sweep and reset abort.
`timescale 1ns/1ps
module tb_map_write_arbiter;

    localparam int NREQ = 10;
    localparam int AW   = 8;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              sweep_start;
    logic [3:0]        sweep_tile;
    logic [NREQ-1:0]   req;
    logic [NREQ*4-1:0] req_x;
    logic [NREQ*4-1:0] req_y;
    logic [NREQ*4-1:0] req_tile;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   drop;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [3:0]        wr_data;
    logic              busy;

    int checks = 0;
    int errors = 0;

    map_write_arbiter #(.NREQ(NREQ), .COLS(16), .ROWS(12), .AW(AW)) dut (
        .Clk(Clk), .Reset(Reset),
        .sweep_start(sweep_start), .sweep_tile(sweep_tile),
        .req(req), .req_x(req_x), .req_y(req_y), .req_tile(req_tile),
        .gnt(gnt), .drop(drop), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input int i, input int x, input int y,
                           input int t);
        req[i]            = 1'b1;
        req_x[i*4 +: 4]   = 4'(x);
        req_y[i*4 +: 4]   = 4'(y);
        req_tile[i*4 +: 4] = 4'(t);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        int seen;
        Reset       = 1'b1;
        sweep_start = 1'b0;
        sweep_tile  = '0;
        req         = '0;
        req_x       = '0;
        req_y       = '0;
        req_tile    = '0;
        tick();
        tick();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_drop", int'(drop), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_addr", int'(wr_addr), 0);
        chk("rst_data", int'(wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        Reset = 1'b0;

        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (wr_en || busy || gnt != 0 || drop != 0) seen++;
        end
        chk("idle_quiet", seen, 0);

        // Single request, held through its gnt cycle.
        set_req(3, 5, 2, 7);
        tick();
        chk("one_gnt", int'(gnt), 32'h008);
        chk("one_wr_en", int'(wr_en), 1);
        chk("one_addr", int'(wr_addr), 37);
        chk("one_data", int'(wr_data), 7);
        tick();
        chk("one_mask_gnt", int'(gnt), 0);
        chk("one_mask_wr", int'(wr_en), 0);
        req[3] = 1'b0;
        tick();
        chk("one_after", int'(gnt), 0);

        // Contention from a fresh pointer.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, i, i % 12, i + 1);
        for (int k = 0; k < NREQ; k++) begin
            tick();
            if (k > 0) req[k-1] = 1'b0;
            chk($sformatf("rr_gnt%0d", k), int'(gnt), 1 << k);
            chk($sformatf("rr_wr%0d", k), int'(wr_en), 1);
            chk($sformatf("rr_addr%0d", k), int'(wr_addr),
                (k % 12) * 16 + k);
            chk($sformatf("rr_data%0d", k), int'(wr_data), k + 1);
        end
        tick();
        req[9] = 1'b0;
        chk("rr_done_gnt", int'(gnt), 0);
        chk("rr_done_wr", int'(wr_en), 0);

        set_req(0, 2, 0, 4'hA);
        set_req(9, 3, 0, 4'hB);
        tick();
        chk("wrap_first", int'(gnt), 1);
        chk("wrap_addr0", int'(wr_addr), 2);
        tick();
        req[0] = 1'b0;
        chk("wrap_second", int'(gnt), 1 << 9);
        chk("wrap_data9", int'(wr_data), 11);
        tick();
        req[9] = 1'b0;
        chk("wrap_idle", int'(gnt), 0);

        // Out-of-range row alongside the last valid cell.
        set_req(8, 0, 12, 4'hC);
        set_req(1, 15, 11, 4'hD);
        tick();
        chk("oor_drop", int'(drop), 1 << 8);
        chk("oor_gnt", int'(gnt), 1 << 1);
        chk("oor_addr", int'(wr_addr), 191);
        chk("oor_data", int'(wr_data), 13);
        tick();
        req[8] = 1'b0;
        req[1] = 1'b0;
        chk("oor_mask_drop", int'(drop), 0);
        chk("oor_mask_gnt", int'(gnt), 0);
        tick();
        chk("oor_quiet", int'(drop | gnt), 0);

        // Sweep with a pending request and a stray restart pulse.
        set_req(5, 3, 4, 9);
        sweep_start = 1'b1;
        sweep_tile  = 4'h2;
        tick();
        sweep_start = 1'b0;
        sweep_tile  = 4'h5;
        chk("sw_start_gnt", int'(gnt), 0);
        chk("sw_start_busy", int'(busy), 1);
        chk("sw_start_wr", int'(wr_en), 1);
        chk("sw_start_addr", int'(wr_addr), 0);
        chk("sw_start_data", int'(wr_data), 2);
        for (int n = 1; n < 192; n++) begin
            tick();
            sweep_start = (n == 100);
            chk($sformatf("sw_addr%0d", n), int'(wr_addr), n);
            chk($sformatf("sw_ctl%0d", n),
                int'({wr_en, busy, wr_data, gnt, drop}),
                int'({1'b1, 1'b1, 4'h2, 10'h0, 10'h0}));
        end
        sweep_start = 1'b0;
        tick();
        chk("sw_end_busy", int'(busy), 0);
        chk("sw_end_gnt", int'(gnt), 1 << 5);
        chk("sw_end_addr", int'(wr_addr), 67);
        chk("sw_end_data", int'(wr_data), 9);
        tick();
        req[5] = 1'b0;
        chk("sw_post_gnt", int'(gnt), 0);
        chk("sw_post_wr", int'(wr_en), 0);

        // Reset in the middle of a sweep.
        sweep_start = 1'b1;
        sweep_tile  = 4'h6;
        tick();
        sweep_start = 1'b0;
        for (int n = 1; n <= 100; n++) tick();
        chk("ab_addr", int'(wr_addr), 100);
        Reset = 1'b1;
        #1;
        chk("ab_wr_en", int'(wr_en), 0);
        chk("ab_busy", int'(busy), 0);
        tick();
        Reset = 1'b0;
        set_req(0, 1, 1, 3);
        tick();
        chk("ab_gnt", int'(gnt), 1);
        chk("ab_gaddr", int'(wr_addr), 17);
        chk("ab_gbusy", int'(busy), 0);
        tick();
        req[0] = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (wr_en || busy) seen++;
        end
        chk("ab_no_resume", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
